// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, default tap table and FSM state type for lfsr_tap_search
// Holds no ports; imported by the interface-facing top and its sub-module.
package lfsr_pkg;
  localparam int WIDTH_DEF = 7;
  localparam int NPAT_DEF = 9;
  localparam int DIST_W_DEF = 4;
  // Maximal-length tap masks for a 7-bit register; entry 0 sits in the LSBs.
  localparam logic [NPAT_DEF*WIDTH_DEF-1:0] TAP_TABLE =
    {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60};
  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;
endpackage

// File: rtl/lfsr_tap_search_if.sv
// lfsr_tap_search_if: request/result bundle between a requester (master) and the search engine (slave)
// Master drives Req, DataA, DataB, Dist; slave drives Busy, Ack, Found, TapIdx, Taps, MatchMask.
interface lfsr_tap_search_if #(
  parameter int WIDTH = 7,
  parameter int NPAT = 9,
  parameter int DIST_W = 4
);
  logic Req;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic [DIST_W-1:0] Dist;
  logic Busy;
  logic Ack;
  logic Found;
  logic [$clog2(NPAT)-1:0] TapIdx;
  logic [WIDTH-1:0] Taps;
  logic [NPAT-1:0] MatchMask;
  modport master (output Req, DataA, DataB, Dist, input Busy, Ack, Found, TapIdx, Taps, MatchMask);
  modport slave (input Req, DataA, DataB, Dist, output Busy, Ack, Found, TapIdx, Taps, MatchMask);
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR step, shifting left with the tap parity entering at the LSB
// Ports: cur_i current state, taps_i tap mask, nxt_o next state.
module lfsr_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] nxt_o
);
  assign nxt_o = {cur_i[WIDTH-2:0], ^(cur_i & taps_i)};
endmodule

// File: rtl/lfsr_tap_search.sv
// lfsr_tap_search: finds which tap pattern carries DataA to DataB in Dist LFSR steps
// Ports: Clk, Reset_n (synchronous, active-low); bus (slave modport): Req/DataA/DataB/Dist in,
//   Busy/Ack/Found/TapIdx/Taps/MatchMask out.
// Define LFSR_SEARCH_ALL_EN to scan every pattern instead of stopping at the first match.
module lfsr_tap_search
  import lfsr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NPAT = NPAT_DEF,
  parameter int DIST_W = DIST_W_DEF,
  parameter logic [NPAT*WIDTH-1:0] TAPS = TAP_TABLE
) (
  input logic Clk,
  input logic Reset_n,
  lfsr_tap_search_if.slave bus
);
  localparam int IW = $clog2(NPAT);
  localparam logic [IW-1:0] LAST = IW'(NPAT - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, tap_idx_q, tap_idx_d;
  logic [WIDTH-1:0] cur_q, cur_d, a_q, a_d, b_q, b_d, taps_q, taps_d, nxt, tap_sel;
  logic [DIST_W-1:0] cnt_q, cnt_d, dist_q, dist_d;
  logic [NPAT-1:0] mask_q, mask_d;
  logic found_q, found_d, hit, stop;
  logic [NPAT-1:0][WIDTH-1:0] tab;
  assign tab = TAPS;
  assign tap_sel = tab[idx_q];
  lfsr_step #(.WIDTH(WIDTH)) u_step (.cur_i(cur_q), .taps_i(tap_sel), .nxt_o(nxt));
  assign hit = cur_q == b_q;
`ifdef LFSR_SEARCH_ALL_EN
  assign stop = idx_q == LAST;
`else
  assign stop = idx_q == LAST || hit;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    dist_d = dist_q;
    found_d = found_q;
    tap_idx_d = tap_idx_q;
    taps_d = taps_q;
    mask_d = mask_q;
    case (state_q)
      IDLE: if (bus.Req) begin
        a_d = bus.DataA;
        b_d = bus.DataB;
        dist_d = bus.Dist;
        idx_d = '0;
        cur_d = bus.DataA;
        cnt_d = bus.Dist;
        found_d = 1'b0;
        tap_idx_d = '0;
        taps_d = '0;
        mask_d = '0;
        state_d = bus.Dist != '0 ? STEP : CHECK;
      end
      STEP: begin
        cur_d = nxt;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_d == '0 ? CHECK : STEP;
      end
      CHECK: begin
        if (hit) begin
          mask_d[idx_q] = 1'b1;
          if (!found_q) begin
            found_d = 1'b1;
            tap_idx_d = idx_q;
            taps_d = tap_sel;
          end
        end
        if (stop) state_d = DONE;
        else begin
          // Restart from the captured start word with the next pattern.
          idx_d = idx_q + 1'b1;
          cur_d = a_q;
          cnt_d = dist_q;
          state_d = dist_q != '0 ? STEP : CHECK;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dist_q <= '0;
      found_q <= 1'b0;
      tap_idx_q <= '0;
      taps_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      dist_q <= dist_d;
      found_q <= found_d;
      tap_idx_q <= tap_idx_d;
      taps_q <= taps_d;
      mask_q <= mask_d;
    end
  end
  assign bus.Busy = state_q != IDLE;
  assign bus.Ack = state_q == DONE;
  assign bus.Found = found_q;
  assign bus.TapIdx = tap_idx_q;
  assign bus.Taps = taps_q;
  assign bus.MatchMask = mask_q;
endmodule

// File: tb/tb_lfsr_tap_search.sv
// tb_lfsr_tap_search: randomized scoreboard bench for lfsr_tap_search against a behavioural search model
module tb_lfsr_tap_search;
`ifdef LFSR_SEARCH_ALL_EN
  localparam bit ALL = 1'b1;
`else
  localparam bit ALL = 1'b0;
`endif
  localparam logic [6:0] TT [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  typedef struct {
    logic found;
    logic [3:0] idx;
    logic [6:0] taps;
    logic [8:0] mask;
    int lat;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t held;
  bit chk_hold = 1'b0;

  always #5 clk = ~clk;

  lfsr_tap_search_if #(.WIDTH(7), .NPAT(9), .DIST_W(4)) bus ();
  lfsr_tap_search #(.WIDTH(7), .NPAT(9), .DIST_W(4)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] run(input logic [6:0] a, input logic [6:0] t, input int d);
    logic [6:0] c;
    c = a;
    for (int i = 0; i < d; i++) c = {c[5:0], ^(c & t)};
    return c;
  endfunction

  function automatic exp_t model(input logic [6:0] a, input logic [6:0] b, input logic [3:0] d);
    exp_t e;
    int last;
    e.found = 1'b0;
    e.idx = '0;
    e.taps = '0;
    e.mask = '0;
    e.acc = 0;
    last = 8;
    for (int p = 0; p < 9; p++) begin
      if (run(a, TT[p], int'(d)) == b) begin
        e.mask[p] = 1'b1;
        if (!e.found) begin
          e.found = 1'b1;
          e.idx = 4'(p);
          e.taps = TT[p];
        end
        if (!ALL) begin
          last = p;
          break;
        end
      end
    end
    e.lat = (last + 1) * (int'(d) + 1) + 1;
    return e;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_ack"}, 32'(bus.Ack), 32'd0);
    chk({tag, "_found"}, 32'(bus.Found), 32'd0);
    chk({tag, "_tapidx"}, 32'(bus.TapIdx), 32'd0);
    chk({tag, "_taps"}, 32'(bus.Taps), 32'd0);
    chk({tag, "_mask"}, 32'(bus.MatchMask), 32'd0);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 400 && bus.Busy; i++) @(negedge clk);
    if (bus.Busy) chk("idle_timeout", 32'(bus.Busy), 32'd0);
  endtask

  task automatic search(input logic [6:0] a, input logic [6:0] b, input logic [3:0] d, input bit spur);
    exp_t e;
    wait_idle();
    bus.DataA = a;
    bus.DataB = b;
    bus.Dist = d;
    bus.Req = 1'b1;
    @(posedge clk);
    e = model(a, b, d);
    e.acc = $time;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_rise", 32'(bus.Busy), 32'd1);
    bus.Req = spur;
    if (spur) begin
      bus.DataA = 7'($urandom);
      bus.DataB = 7'($urandom);
      bus.Dist = 4'($urandom);
      @(negedge clk);
      bus.Req = 1'b0;
    end
  endtask

  task automatic b2b(input logic [6:0] a, input logic [6:0] b, input logic [3:0] d);
    exp_t e1, e2;
    wait_idle();
    bus.DataA = a;
    bus.DataB = b;
    bus.Dist = d;
    bus.Req = 1'b1;
    @(posedge clk);
    e1 = model(a, b, d);
    e1.acc = $time;
    e2 = e1;
    e2.acc = $time + longint'((e1.lat + 1) * 10);
    sb.push_back(e1);
    sb.push_back(e2);
    repeat (e1.lat + 1) @(posedge clk);
    @(negedge clk);
    bus.Req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_hold) begin
        chk("ack_one_cycle", 32'(bus.Ack), 32'd0);
        chk("busy_fall", 32'(bus.Busy), 32'd0);
        chk("hold_found", 32'(bus.Found), 32'(held.found));
        chk("hold_mask", 32'(bus.MatchMask), 32'(held.mask));
        chk_hold = 1'b0;
      end
      if (bus.Ack) begin
        if (sb.size() == 0) chk("unexpected_ack", 32'(bus.Ack), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(($time + 5 - e.acc) / 10), 32'(e.lat));
          chk("busy_at_ack", 32'(bus.Busy), 32'd1);
          chk("found", 32'(bus.Found), 32'(e.found));
          chk("tapidx", 32'(bus.TapIdx), 32'(e.idx));
          chk("taps", 32'(bus.Taps), 32'(e.taps));
          chk("mask", 32'(bus.MatchMask), 32'(e.mask));
          held = e;
          chk_hold = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [6:0] a, b;
    logic [3:0] d;
    bus.Req = 1'b0;
    bus.DataA = '0;
    bus.DataB = '0;
    bus.Dist = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    search(7'h01, 7'h03, 4'd1, 1'b1);
    search(7'h40, 7'h01, 4'd1, 1'b0);
    search(7'h01, 7'h05, 4'd1, 1'b0);
    search(7'h2A, 7'h2A, 4'd0, 1'b1);
    search(7'h00, 7'h00, 4'd3, 1'b0);
    search(7'h00, 7'h11, 4'd2, 1'b0);
    wait_idle();
    bus.DataA = 7'h01;
    bus.DataB = 7'h05;
    bus.Dist = 4'd15;
    bus.Req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_ack_after_reset", 32'(sb.size()), 32'd0);
    search(7'h01, 7'h03, 4'd1, 1'b0);
    b2b(7'h2A, 7'h2A, 4'd0);
    b2b(7'h01, 7'h03, 4'd2);
    for (int n = 0; n < 40; n++) begin
      d = 4'($urandom_range(0, 15));
      a = $urandom_range(0, 7) == 0 ? 7'h00 : 7'($urandom);
      b = $urandom_range(0, 1) == 1 ? run(a, TT[$urandom_range(0, 8)], int'(d)) : 7'($urandom);
      search(a, b, d, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_tap_search.md
# lfsr_tap_search

Parametrised sequential LFSR tap-pattern search engine for the program-2 decryption datapath. The block receives an observed start word, an observed end word and an LFSR step distance. It then walks a table of maximal-length tap patterns, clocking an internal LFSR for each one, and reports which pattern carries the start word to the end word. It replaces a flat lookup table with a generic engine that works for any width, pattern count and multi-step distance, and it signals search completion and "no match" through a Req/Ack handshake.

## Interface
- WIDTH, 7: LFSR/data word width.
- NPAT, 9: number of tap patterns in the table.
- DIST_W, 4: width of the step-distance input.
- TAPS, lfsr_pkg::TAP_TABLE: NPAT×WIDTH packed tap masks; entry 0 in the LSBs.
- Clk  input  1  sole clock, rising-edge.
- Reset_n  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- Req  input  1  start request; sampled only in IDLE.
- DataA  input  WIDTH  observed start word.
- DataB  input  WIDTH  observed end word.
- Dist  input  DIST_W  LFSR steps from DataA to DataB.
- Busy  output  1  high from accept until Ack.
- Ack  output  1  one-cycle completion pulse.
- Found  output  1  a matching pattern exists.
- TapIdx  output  $clog2(NPAT)  index of lowest matching pattern (0 if none).
- Taps  output  WIDTH  tap mask of TapIdx (0 if none).
- MatchMask  output  NPAT  per-pattern match bits.

## Operation
- LFSR step: next = {cur[WIDTH-2:0], ^(cur & taps)}. The register shifts left and the feedback bit enters at the LSB.
- States: IDLE, STEP, CHECK, DONE.
- IDLE:
  - When Req=1, capture DataA, DataB and Dist.
  - Set idx=0, cur=DataA, cnt=Dist.
  - Go to STEP if Dist≠0, else go to CHECK.
- STEP:
  - Each cycle, cur ← next(cur, TAPS[idx]) and cnt ← cnt−1.
  - Go to CHECK on the cycle that cnt reaches 0.
- CHECK:
  - If cur==B, set MatchMask[idx].
  - If cur==B and this is the first match, load Found=1, TapIdx=idx and Taps=TAPS[idx].
  - Terminate and go to DONE when idx==NPAT−1, or when a match occurs and early stop applies (see Configuration).
  - Otherwise: idx++, cur=A, cnt=Dist, then go to STEP (or stay in CHECK when Dist=0).
- DONE:
  - Ack=1 for exactly one cycle, then return to IDLE.
  - Results hold until the next accepted Req, which clears Found, TapIdx, Taps and MatchMask.
- Req during STEP, CHECK or DONE is ignored; it is not queued.
- An all-zero state is a fixed point of the step:
  - A=0 matches every pattern only if B=0.
  - A=0 with B≠0 never matches.
- Dist is unsigned. Dist=0 compares A==B directly.

## Timing
- Reset_n=0 at a clock edge forces IDLE. Reset values: Busy=0, Ack=0, Found=0, TapIdx=0, Taps=0, MatchMask=0, internal registers 0.
- Reset mid-search abandons the search; no Ack is issued.
- Busy rises on the edge after Req is sampled in IDLE and falls together with the Ack cycle's end.
- Each pattern costs Dist+1 cycles: Dist STEP cycles plus 1 CHECK cycle.
- Ack asserts exactly (k+1)·(Dist+1)+1 edges after the accepting edge, where k is the last pattern examined.
- Worst case is NPAT·(2^DIST_W)+1 cycles.
- Result outputs are valid on the Ack cycle and stable afterwards.
- Req held high through DONE is re-accepted on the first IDLE cycle, so back-to-back searches are separated by one idle cycle.

## Configuration
- LFSR_SEARCH_ALL_EN defined:
  - No early stop; every pattern is checked, so k = NPAT−1 always.
  - MatchMask reports all matching patterns.
  - Found, TapIdx and Taps report the lowest matching index.
- LFSR_SEARCH_ALL_EN undefined:
  - The search stops at the first match.
  - MatchMask has at most one bit set.

## Structure
- Package lfsr_pkg holds:
  - TAP_TABLE default for WIDTH=7: {7'h7B,7'h7E,7'h5C,7'h69,7'h6A,7'h72,7'h78,7'h48,7'h60}, with entry 0 = 7'h60.
  - The state enum (IDLE, STEP, CHECK, DONE).
  - Default parameter constants.
- Sub-module lfsr_step is combinational and computes the next state from cur and taps, parametrised by WIDTH.
- The top module holds the FSM, counters and result registers.

## Test plan
- A=7'h01, B=7'h03, Dist=1, macro off → Ack at edge 13, Found=1, TapIdx=5, Taps=7'h69, MatchMask=9'h020.
- Same stimulus, macro on → Ack at edge 19, TapIdx=5, MatchMask=9'h120.
- A=7'h40, B=7'h01, Dist=1, macro on → MatchMask=9'h1FF, TapIdx=0, Taps=7'h60.
- A=7'h01, B=7'h05, Dist=1 → Ack at edge 19, Found=0, TapIdx=0, Taps=0, MatchMask=0.
- A=B=7'h2A, Dist=0, macro off → Ack at edge 2, Found=1, TapIdx=0. Req pulsed while Busy has no effect.
- Reset_n=0 on edge 5 of a Dist=15 search → all outputs 0, no Ack. A new Req after reset completes normally.
